// File: rtl/lsu.sv
// RV32I load/store unit: IDLE -> ACCESS -> WB sequencer with byte-lane placement and load extension.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with done+err.
module lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [11:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  reg_write_select,
  output logic [31:0] reg_write_data,
  output logic        reg_write_control
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WB = 2'd2} state_t;

  state_t      state_r;
  logic        busy_r, done_r, err_r, mem_req_r, mem_we_r, rwc_r;
  logic [31:0] mem_addr_r, mem_wdata_r, rwd_r;
  logic [3:0]  mem_wstrb_r;
  logic [4:0]  rws_r, rd_r;
  logic        is_store_r;
  logic [2:0]  funct3_r;
  logic [1:0]  lo_r;
  logic [31:0] addr_s;
  logic        misalign_s;
  logic        req_ok_s;

  function automatic logic legal_f(input logic st, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: legal_f = 1'b1;
      3'b100, 3'b101:         legal_f = ~st;
      default:                legal_f = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] strobe_f(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   strobe_f = 4'b0001 << lo;
      2'b01:   strobe_f = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   strobe_f = 4'b1111;
      default: strobe_f = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   wdata_f = {4{d[7:0]}};
      2'b01:   wdata_f = {2{d[15:0]}};
      default: wdata_f = d;
    endcase
  endfunction

  function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [1:0] lo,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_f = {{24{b[7]}}, b};
      3'b001:  load_f = {{16{h[15]}}, h};
      3'b100:  load_f = {24'h000000, b};
      3'b101:  load_f = {16'h0000, h};
      default: load_f = w;
    endcase
  endfunction

  assign addr_s = base + {{20{offset[11]}}, offset};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = ((funct3[1:0] == 2'b01) && addr_s[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr_s[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign req_ok_s = legal_f(is_store, funct3) && !misalign_s;

  // Sequencer: every output is a register so nothing on the bus depends combinationally on start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wstrb_r <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
      rws_r       <= 5'd0;
      rwd_r       <= 32'h0000_0000;
      rwc_r       <= 1'b0;
      rd_r        <= 5'd0;
      is_store_r  <= 1'b0;
      funct3_r    <= 3'b000;
      lo_r        <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          err_r  <= 1'b0;
          rwc_r  <= 1'b0;
          if (start) begin
            if (req_ok_s) begin
              state_r     <= ACCESS;
              busy_r      <= 1'b1;
              mem_req_r   <= 1'b1;
              mem_we_r    <= is_store;
              mem_addr_r  <= {addr_s[31:2], 2'b00};
              mem_wstrb_r <= is_store ? strobe_f(funct3, addr_s[1:0]) : 4'b0000;
              mem_wdata_r <= wdata_f(funct3, store_data);
              rd_r        <= rd;
              is_store_r  <= is_store;
              funct3_r    <= funct3;
              lo_r        <= addr_s[1:0];
            end else begin
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state_r     <= WB;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wstrb_r <= 4'b0000;
            done_r      <= 1'b1;
            rwc_r       <= !is_store_r && (rd_r != 5'd0);
            rws_r       <= rd_r;
            rwd_r       <= is_store_r ? rwd_r : load_f(funct3_r, lo_r, mem_rdata);
          end
        end
        WB: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          rwc_r   <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          err_r     <= 1'b0;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
          rwc_r     <= 1'b0;
        end
      endcase
    end
  end

  assign busy              = busy_r;
  assign done              = done_r;
  assign err               = err_r;
  assign mem_req           = mem_req_r;
  assign mem_we            = mem_we_r;
  assign mem_addr          = mem_addr_r;
  assign mem_wstrb         = mem_wstrb_r;
  assign mem_wdata         = mem_wdata_r;
  assign reg_write_select  = rws_r;
  assign reg_write_data    = rwd_r;
  assign reg_write_control = rwc_r;

endmodule

// File: tb/tb_lsu.sv
// Directed table-driven bench for lsu, plus hand sequences for reset abort and start-while-busy.
module tb_lsu;

  logic        clk, reset, start, is_store, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] base, store_data, mem_rdata;
  logic [11:0] offset;
  logic [4:0]  rd;
  logic        busy, done, err, mem_req, mem_we, reg_write_control;
  logic [31:0] mem_addr, mem_wdata, reg_write_data;
  logic [3:0]  mem_wstrb;
  logic [4:0]  reg_write_select;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  lsu dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data), .rd(rd),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .reg_write_select(reg_write_select), .reg_write_data(reg_write_data),
    .reg_write_control(reg_write_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for the start-while-busy sequence.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] off;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_rwc;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] b,
                              input logic [11:0] o, input logic [31:0] sd, input logic [4:0] r,
                              input logic [31:0] rdat, input int w, input logic e,
                              input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                              input logic c, input logic [31:0] d);
    vec_t v;
    v.st = st; v.f3 = f3; v.base = b; v.off = o; v.sd = sd; v.rd = r; v.rdata = rdat;
    v.waits = w; v.exp_err = e; v.exp_addr = a; v.exp_strb = s; v.exp_wdata = wd;
    v.exp_rwc = c; v.exp_rdat = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input int idx, input vec_t v);
    string n;
    n = $sformatf("v%0d", idx);
    @(negedge clk);
    start = 1'b1; is_store = v.st; funct3 = v.f3; base = v.base; offset = v.off;
    store_data = v.sd; rd = v.rd;
    @(negedge clk);
    start = 1'b0;
    if (v.exp_err) begin
      chk({n, " err.done"}, {31'd0, done}, 32'd1);
      chk({n, " err.err"}, {31'd0, err}, 32'd1);
      chk({n, " err.mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({n, " err.busy"}, {31'd0, busy}, 32'd0);
      chk({n, " err.rwc"}, {31'd0, reg_write_control}, 32'd0);
      @(negedge clk);
      chk({n, " err.done_drop"}, {30'd0, done, err}, 32'd0);
      chk({n, " err.still_idle"}, {30'd0, busy, mem_req}, 32'd0);
      return;
    end
    chk({n, " req"}, {31'd0, mem_req}, 32'd1);
    chk({n, " busy"}, {31'd0, busy}, 32'd1);
    chk({n, " we"}, {31'd0, mem_we}, {31'd0, v.st});
    chk({n, " addr"}, mem_addr, v.exp_addr);
    chk({n, " strb"}, {28'd0, mem_wstrb}, {28'd0, v.exp_strb});
    if (v.st) chk({n, " wdata"}, mem_wdata, v.exp_wdata);
    chk({n, " no_early_done"}, {31'd0, done}, 32'd0);
    for (int i = 0; i < v.waits; i++) begin
      @(negedge clk);
      chk({n, " hold.req"}, {31'd0, mem_req}, 32'd1);
      chk({n, " hold.addr"}, mem_addr, v.exp_addr);
      chk({n, " hold.strb"}, {28'd0, mem_wstrb}, {28'd0, v.exp_strb});
      if (v.st) chk({n, " hold.wdata"}, mem_wdata, v.exp_wdata);
      chk({n, " hold.done"}, {31'd0, done}, 32'd0);
    end
    mem_ready = 1'b1; mem_rdata = v.rdata;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    chk({n, " done"}, {31'd0, done}, 32'd1);
    chk({n, " err"}, {31'd0, err}, 32'd0);
    chk({n, " wb.req"}, {31'd0, mem_req}, 32'd0);
    chk({n, " rwc"}, {31'd0, reg_write_control}, {31'd0, v.exp_rwc});
    if (v.exp_rwc) begin
      chk({n, " rws"}, {27'd0, reg_write_select}, {27'd0, v.rd});
      chk({n, " rwd"}, reg_write_data, v.exp_rdat);
    end
    @(negedge clk);
    chk({n, " after.done"}, {31'd0, done}, 32'd0);
    chk({n, " after.rwc"}, {31'd0, reg_write_control}, 32'd0);
    chk({n, " after.busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0, e0;
    vecs[0]  = mk(1'b0, 3'b010, 32'h0000_1000, 12'h004, 32'h0, 5'd5, 32'hDEAD_BEEF, 0,
                  1'b0, 32'h0000_1004, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    vecs[1]  = mk(1'b0, 3'b000, 32'h0000_2003, 12'h000, 32'h0, 5'd3, 32'h80FF_FFFF, 0,
                  1'b0, 32'h0000_2000, 4'h0, 32'h0, 1'b1, 32'hFFFF_FF80);
    vecs[2]  = mk(1'b0, 3'b100, 32'h0000_2003, 12'h000, 32'h0, 5'd4, 32'h80FF_FFFF, 0,
                  1'b0, 32'h0000_2000, 4'h0, 32'h0, 1'b1, 32'h0000_0080);
    vecs[3]  = mk(1'b1, 3'b001, 32'h0000_3000, 12'hFFE, 32'h1234_ABCD, 5'd0, 32'h0, 3,
                  1'b0, 32'h0000_2FFC, 4'hC, 32'hABCD_ABCD, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[4]  = mk(1'b0, 3'b010, 32'h0000_1002, 12'h000, 32'h0, 5'd6, 32'h1122_3344, 0,
                  1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
`else
    vecs[4]  = mk(1'b0, 3'b010, 32'h0000_1002, 12'h000, 32'h0, 5'd6, 32'h1122_3344, 0,
                  1'b0, 32'h0000_1000, 4'h0, 32'h0, 1'b1, 32'h1122_3344);
`endif
    vecs[5]  = mk(1'b0, 3'b001, 32'h0000_0100, 12'h002, 32'h0, 5'd9, 32'h8001_7FFF, 1,
                  1'b0, 32'h0000_0100, 4'h0, 32'h0, 1'b1, 32'hFFFF_8001);
    vecs[6]  = mk(1'b0, 3'b101, 32'h0000_0100, 12'h000, 32'h0, 5'd10, 32'h8001_7FFF, 0,
                  1'b0, 32'h0000_0100, 4'h0, 32'h0, 1'b1, 32'h0000_7FFF);
    vecs[7]  = mk(1'b1, 3'b000, 32'h0000_0041, 12'h001, 32'h0000_00A5, 5'd0, 32'h0, 2,
                  1'b0, 32'h0000_0040, 4'h4, 32'hA5A5_A5A5, 1'b0, 32'h0);
    vecs[8]  = mk(1'b1, 3'b010, 32'hFFFF_FFFC, 12'h008, 32'hCAFE_F00D, 5'd0, 32'h0, 0,
                  1'b0, 32'h0000_0004, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0);
    vecs[9]  = mk(1'b0, 3'b010, 32'h0000_0020, 12'h000, 32'h0, 5'd0, 32'h1234_5678, 0,
                  1'b0, 32'h0000_0020, 4'h0, 32'h0, 1'b0, 32'h0);
    vecs[10] = mk(1'b0, 3'b011, 32'h0000_0040, 12'h000, 32'h0, 5'd2, 32'h0, 0,
                  1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    vecs[11] = mk(1'b1, 3'b100, 32'h0000_0040, 12'h000, 32'h0, 5'd0, 32'h0, 0,
                  1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    vecs[12] = mk(1'b0, 3'b000, 32'h0000_0010, 12'h7FF, 32'h0, 5'd1, 32'h7F00_0000, 0,
                  1'b0, 32'h0000_080C, 4'h0, 32'h0, 1'b1, 32'h0000_007F);
    vecs[13] = mk(1'b0, 3'b100, 32'h0000_0000, 12'h801, 32'h0, 5'd31, 32'h0000_C300, 0,
                  1'b0, 32'hFFFF_F800, 4'h0, 32'h0, 1'b1, 32'h0000_00C3);

    reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; base = 32'h0;
    offset = 12'h0; store_data = 32'h0; rd = 5'd0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("reset.ctrl", {25'd0, busy, done, err, mem_req, mem_we, reg_write_control, 1'b0}, 32'd0);
    chk("reset.addr", mem_addr, 32'h0);
    chk("reset.wdata", mem_wdata, 32'h0);
    chk("reset.strb_sel", {23'd0, mem_wstrb, reg_write_select}, 32'd0);
    chk("reset.rwd", reg_write_data, 32'h0);
    @(posedge clk); #2 reset = 1'b1;

    for (int i = 0; i < 14; i++) do_op(i, vecs[i]);

    // Reset in the middle of an ACCESS must abort it without a write or done.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h0000_0700; offset = 12'h0; rd = 5'd7;
    @(negedge clk);
    start = 1'b0;
    chk("rst_abort.req_before", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    chk("rst_abort.req", {31'd0, mem_req}, 32'd0);
    chk("rst_abort.busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    chk("rst_abort.rwc", {31'd0, reg_write_control}, 32'd0);
    chk("rst_abort.rws", {27'd0, reg_write_select}, 32'd0);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    @(posedge clk); #2 reset = 1'b1;
    do_op(100, mk(1'b0, 3'b010, 32'h0000_0700, 12'h000, 32'h0, 5'd7, 32'h0BAD_F00D, 0,
                  1'b0, 32'h0000_0700, 4'h0, 32'h0, 1'b1, 32'h0BAD_F00D));

    // Illegal load, then a SW that sees further starts while busy.
    @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b011; base = 32'h0000_0600; rd = 5'd8;
    @(negedge clk);
    chk("busy_seq.err", {30'd0, done, err}, 32'd3);
    is_store = 1'b1; funct3 = 3'b010; base = 32'h0000_0500; offset = 12'h0;
    store_data = 32'h1122_3344; rd = 5'd0;
    @(negedge clk);
    chk("busy_seq.sw_addr", mem_addr, 32'h0000_0500);
    is_store = 1'b0; funct3 = 3'b011; base = 32'h0000_0900; rd = 5'd12;
    @(negedge clk);
    chk("busy_seq.no_err", {31'd0, err}, 32'd0);
    chk("busy_seq.addr_kept", mem_addr, 32'h0000_0500);
    chk("busy_seq.wdata_kept", mem_wdata, 32'h1122_3344);
    chk("busy_seq.we_kept", {27'd0, mem_we, mem_wstrb}, 32'h1F);
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("busy_seq.sw_done", {30'd0, done, err}, 32'd2);
    chk("busy_seq.sw_rwc", {31'd0, reg_write_control}, 32'd0);
    @(negedge clk);
    chk("busy_seq.idle", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    chk("busy_seq.done_pulses", done_cnt - d0, 32'd2);
    chk("busy_seq.err_pulses", err_cnt - e0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters SHALL be none; all widths fixed for RV32I.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 start  input  1  request pulse; accepted only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load; sampled with start.
REQ-006 funct3  input  3  RV32I width/sign code; sampled with start.
REQ-007 base  input  32  rs1 value from register file read port; sampled with start.
REQ-008 offset  input  12  signed immediate; sampled with start.
REQ-009 store_data  input  32  rs2 value; sampled with start.
REQ-010 rd  input  5  load destination; sampled with start.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle pulse coincident with done on a rejected access.
REQ-014 mem_req / mem_we  output  1 / 1  bus request / write enable.
REQ-015 mem_addr  output  32  word address, bits [1:0] always 0.
REQ-016 mem_wstrb / mem_wdata  output  4 / 32  byte strobes / lane-placed store data.
REQ-017 mem_ready / mem_rdata  input  1 / 32  bus completion / read word, valid when mem_ready=1.
REQ-018 reg_write_select / reg_write_data / reg_write_control  output  5 / 32 / 1  register-file write port.

Function
REQ-019 States SHALL be IDLE, ACCESS, WB; IDLE->ACCESS on start with a valid, aligned request; ACCESS->WB on mem_ready=1; WB->IDLE unconditionally.
REQ-020 Effective address SHALL be base + sign-extended offset, modulo 2^32 (wrap-around, no error).
REQ-021 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-022 Illegal funct3 on start in IDLE SHALL produce done=1, err=1 the next cycle, no mem_req, no register write, and remain IDLE.
REQ-023 In ACCESS, mem_req=1 and mem_addr/mem_we/mem_wstrb/mem_wdata SHALL hold stable until the cycle mem_ready=1 is sampled.
REQ-024 mem_req SHALL first assert the cycle after start; no combinational path from start to mem_*.
REQ-025 Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011 (addr[1]=0) or 4'b1100; SW 4'b1111; loads 4'b0000.
REQ-026 Store data: SB byte replicated in all four lanes; SH halfword replicated in both halves; SW unchanged.
REQ-027 Load extraction: byte/halfword selected by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-028 Load in WB: reg_write_control=1 for exactly one cycle, reg_write_select=rd, reg_write_data=extended value; done=1 same cycle.
REQ-029 Load with rd=0 SHALL perform the bus access but keep reg_write_control=0; done still pulses.
REQ-030 Store in WB: done=1, reg_write_control=0.
REQ-031 Best-case latency: start in cycle N, mem_ready in N+1, done in N+2; each extra wait cycle adds one.
REQ-032 start while busy=1 SHALL be ignored with no effect on the in-flight access.
REQ-033 reg_write_control SHALL be 0 in every cycle other than a load WB cycle.

Reset
REQ-034 On reset=0 (asynchronous): state=IDLE; busy, done, err, mem_req, mem_we, reg_write_control = 0; mem_addr, mem_wstrb, mem_wdata, reg_write_select, reg_write_data = 0.
REQ-035 Reset during ACCESS or WB SHALL abort immediately: mem_req drops without waiting for mem_ready, no register write, no done.
REQ-036 After reset release, the first rising edge SHALL accept start.

Configuration
REQ-037 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL behave as REQ-022 (done+err, no access).
REQ-038 Macro LSU_MISALIGN_TRAP_EN undefined: misalignment SHALL NOT be checked; halfword uses addr[1] only, word ignores addr[1:0]; err asserts only for illegal funct3.

Verification
REQ-039 LW base=0x1000, offset=0x004, rd=5, mem_ready on first ACCESS cycle, rdata=0xDEADBEEF -> mem_addr=0x1004, done at N+2, x5 write 0xDEADBEEF.
REQ-040 LB base=0x2003, offset=0, rdata=0x80FFFFFF; LBU same -> writes 0xFFFFFF80 and 0x00000080.
REQ-041 SH base=0x3000, offset=0xFFE (-2), store_data=0x1234ABCD, 3 wait cycles -> mem_addr=0x2FFC, wstrb=4'b1100, wdata=0xABCDABCD held 4 cycles, done at N+5, no reg write.
REQ-042 LW base=0x1002 -> with LSU_MISALIGN_TRAP_EN: done+err at N+1, no mem_req; without: mem_addr=0x1000, normal load.
REQ-043 reset=0 asserted mid-ACCESS of LW rd=7 -> mem_req=0 same cycle, no write to x7, no done; next start after release completes normally.
REQ-044 start with funct3=3'b011 load, then start pulses during a following busy SW -> err pulse once; extra starts ignored; exactly one SW done.
